// File: rtl/add_req_arbiter.sv
// add_req_arbiter: round-robin sharing of one external adder among N_REQ
// requesters. Operands are registered toward the adder. Each issued op is
// tagged with its requester id through an ADD_LAT-deep pipeline. Results
// land in a first-word-fall-through response FIFO. An outstanding-op credit
// counter keeps that FIFO from ever overflowing.
//
// Handshake rule, used on every interface of this block: a transfer happens
// in a cycle where valid and ready are both 1 at the rising edge. A
// requester that raises valid keeps valid and its operands stable until it
// sees ready. req_ready never depends on anything except req_valid, the
// round-robin pointer, the registered credit count and reset.
module add_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int add_width = 4,
  parameter int ADD_LAT   = 1,
  parameter int RSP_DEPTH = 4,
  localparam int IDW      = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*add_width-1:0] req_a,
  input  logic [N_REQ*add_width-1:0] req_b,
  input  logic [N_REQ-1:0]           req_cin,
  output logic                       add_valid,
  output logic [add_width-1:0]       add_a,
  output logic [add_width-1:0]       add_b,
  output logic                       add_cin,
  input  logic [add_width-1:0]       add_sum,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [add_width-1:0]       rsp_sum,
  output logic                       rsp_cout,
  output logic                       busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int EW = IDW + 1 + add_width;

  logic [IDW-1:0]         ptr;
  logic [CW-1:0]          outstanding;
  logic                   eligible;
  logic                   grant_found;
  logic [IDW-1:0]         grant_id;
  logic [IDW-1:0]         scan_id;
  logic                   hs;
  logic [IDW-1:0]         iss_id;
  logic [ADD_LAT-1:0]     tag_v;
  logic [ADD_LAT*IDW-1:0] tag_id;
  logic [ADD_LAT:0]       tag_v_ext;
  logic [(ADD_LAT+1)*IDW-1:0] tag_id_ext;
  logic                   push;
  logic                   pop;
  logic [IDW-1:0]         tail_id;
  logic [EW-1:0]          fifo_mem [RSP_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic [EW-1:0]          fifo_head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RSP_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit check uses the registered count, so a pop frees a slot next cycle.
  assign eligible = (outstanding < CW'(RSP_DEPTH));

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = IDW'((int'(ptr) + k) % N_REQ);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  // Grant is forced low while reset is asserted.
  assign hs        = rst && eligible && grant_found;
  assign req_ready = hs ? (N_REQ'(1) << grant_id) : '0;

  // Pointer moves just past the winner on every handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Register the winner's operands toward the adder; data holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      iss_id    <= '0;
    end else begin
      add_valid <= hs;
      if (hs) begin
        add_a   <= req_a[grant_id*add_width +: add_width];
        add_b   <= req_b[grant_id*add_width +: add_width];
        add_cin <= req_cin[grant_id];
        iss_id  <= grant_id;
      end
    end
  end

  assign tag_v_ext  = {tag_v, add_valid};
  assign tag_id_ext = {tag_id, iss_id};

  // Tag pipeline tracks which requester owns the result arriving each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= tag_v_ext[ADD_LAT-1:0];
      tag_id <= tag_id_ext[ADD_LAT*IDW-1:0];
    end
  end

  assign push    = tag_v[ADD_LAT-1];
  assign tail_id = tag_id[ADD_LAT*IDW-1 -: IDW];
  assign pop     = rsp_valid && rsp_ready;

  // Response storage; contents need no reset since fifo_cnt qualifies them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tail_id, add_cout, add_sum};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits: one per op from grant until its response is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign fifo_head = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_id    = rsp_valid ? fifo_head[EW-1 -: IDW] : '0;
  assign rsp_cout  = rsp_valid ? fifo_head[add_width] : 1'b0;
  assign rsp_sum   = rsp_valid ? fifo_head[add_width-1:0] : '0;
  assign busy      = (outstanding != '0);

  // The credit scheme makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_cnt == CW'(RSP_DEPTH))));

endmodule
